fifo_wptr_full_ctrl: RTL and testbench

//  Write-domain pointer/flag stage of the async FIFO. Owns the binary write pointer and
//  the RAM write address. Publishes the Gray-coded write pointer for the read domain.

---
 rtl/fifo_wptr_full_ctrl_if.sv | 26 ++
 rtl/fifo_wptr_full_ctrl.sv | 99 +++++++++
 tb/tb_fifo_wptr_full_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wptr_full_ctrl_if.sv
// Write-side bundle of the async FIFO pointer/flag stage: request, remote Gray pointer,
// RAM write port and status flags.
interface fifo_wptr_full_ctrl_if #(
   parameter int unsigned ADDR = 5
) ();
   logic            winc;
   logic [ADDR:0]   rptr_gray_async;
   logic [ADDR-1:0] waddr;
   logic            wen;
   logic [ADDR:0]   wptr_bin;
   logic [ADDR:0]   wptr_gray;
   logic [ADDR:0]   rptr_bin_sync;
   logic            full;
   logic            overflow_err;
   logic            almost_full;

   modport master (
      output winc, rptr_gray_async,
      input  waddr, wen, wptr_bin, wptr_gray, rptr_bin_sync, full, overflow_err, almost_full
   );

   modport slave (
      input  winc, rptr_gray_async,
      output waddr, wen, wptr_bin, wptr_gray, rptr_bin_sync, full, overflow_err, almost_full
   );
endinterface

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain pointer, Gray publication, read-pointer synchroniser and full flag of the async FIFO.
// Optional almost-full flag enabled by defining FIFO_WR_ALMOST_FULL_EN.
module fifo_wptr_full_ctrl #(
   parameter int unsigned ADDR        = 5,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AF_LEVEL    = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   fifo_wptr_full_ctrl_if.slave  bus
);
   localparam int unsigned PW = ADDR + 1;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("SYNC_STAGES must be 2..3");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > (2 ** ADDR) - 1) begin : g_bad_af
      $error("AF_LEVEL must be 1..2**ADDR-1");
   end

   logic [PW-1:0] bin_q;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_q;
   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] rbin;
   logic          full_q;
   logic          full_next;
   logic          ovf_q;
   logic          accept;
   logic          af_q;

   // Next pointer and full decision against the currently synchronised read pointer
   always_comb begin
      accept    = bus.winc & ~full_q;
      bin_next  = accept ? bin_q + PW'(1) : bin_q;
      full_next = (bin_next[ADDR] != rbin[ADDR]) &&
                  (bin_next[ADDR-1:0] == rbin[ADDR-1:0]);
   end

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      rbin = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         rbin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.rptr_gray_async;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         bin_q  <= bin_next;
         gray_q <= bin_next ^ (bin_next >> 1);
         full_q <= full_next;
         ovf_q  <= ovf_q | (bus.winc & full_q);
      end
   end

`ifdef FIFO_WR_ALMOST_FULL_EN
   logic [PW-1:0] level;

   assign level = bin_next - rbin;

   always_ff @(posedge clk) begin
      if (rst) begin
         af_q <= 1'b0;
      end else begin
         af_q <= (level >= PW'(AF_LEVEL));
      end
   end
`else
   assign af_q = 1'b0;
`endif

   assign bus.waddr         = bin_q[ADDR-1:0];
   assign bus.wen           = accept;
   assign bus.wptr_bin      = bin_q;
   assign bus.wptr_gray     = gray_q;
   assign bus.rptr_bin_sync = rbin;
   assign bus.full          = full_q;
   assign bus.overflow_err  = ovf_q;
   assign bus.almost_full   = af_q;
endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Self-checking bench for fifo_wptr_full_ctrl (ADDR=2, SYNC_STAGES=2, AF_LEVEL=3),
// scoreboarded against an occupancy-based model of the write side.
module tb_fifo_wptr_full_ctrl;
   localparam int unsigned ADDR  = 2;
   localparam int          DEPTH = 4;
   localparam int          PMOD  = 8;

   logic clk;
   logic rst;

   fifo_wptr_full_ctrl_if #(.ADDR(ADDR)) bus ();

   fifo_wptr_full_ctrl #(.ADDR(ADDR), .SYNC_STAGES(2), .AF_LEVEL(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Model: write count and the read pointer as seen after each synchroniser stage
   int m_w     = 0;
   int m_sync0 = 0;
   int m_sync1 = 0;
   bit m_full  = 0;
   bit m_ovf   = 0;
   bit m_af    = 0;
   int rd_ptr  = 0;

   task automatic cyc(input bit r, input bit w, input int rd);
      bit exp_wen;
      int acc;
      int wn;
      int occ;
      rst                 = r;
      bus.winc            = w;
      bus.rptr_gray_async = 3'(rd ^ (rd >> 1));
      #1;
      exp_wen = w && !m_full;
      vectors++;
      if (bus.wen !== exp_wen) begin
         miscompares++;
         $display("FAIL wen: got %b want %b", bus.wen, exp_wen);
      end
      @(posedge clk);
      if (r) begin
         m_w = 0; m_sync0 = 0; m_sync1 = 0;
         m_full = 0; m_ovf = 0; m_af = 0;
      end else begin
         acc   = (w && !m_full) ? 1 : 0;
         wn    = (m_w + acc) % PMOD;
         occ   = (wn - m_sync1 + PMOD) % PMOD;
         m_ovf = m_ovf | (w && m_full);
         m_full = (occ == DEPTH);
`ifdef FIFO_WR_ALMOST_FULL_EN
         m_af  = (occ >= 3);
`else
         m_af  = 0;
`endif
         m_sync1 = m_sync0;
         m_sync0 = rd;
         m_w     = wn;
      end
      #1;
      vectors++;
      if (bus.wptr_bin !== 3'(m_w) || bus.waddr !== 2'(m_w) ||
          bus.wptr_gray !== 3'(m_w ^ (m_w >> 1))) begin
         miscompares++;
         $display("FAIL ptr: got bin=%b addr=%b gray=%b want bin=%b gray=%b",
                  bus.wptr_bin, bus.waddr, bus.wptr_gray, 3'(m_w), 3'(m_w ^ (m_w >> 1)));
      end
      vectors++;
      if (bus.rptr_bin_sync !== 3'(m_sync1)) begin
         miscompares++;
         $display("FAIL rptr_sync: got %b want %b", bus.rptr_bin_sync, 3'(m_sync1));
      end
      vectors++;
      if (bus.full !== m_full || bus.overflow_err !== m_ovf || bus.almost_full !== m_af) begin
         miscompares++;
         $display("FAIL flags: got full=%b ovf=%b af=%b want full=%b ovf=%b af=%b",
                  bus.full, bus.overflow_err, bus.almost_full, m_full, m_ovf, m_af);
      end
   endtask

   task automatic test_reset();
      rd_ptr = 0;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      vectors++;
      if (bus.wptr_bin !== 3'b000 || bus.wptr_gray !== 3'b000 || bus.full !== 1'b0 ||
          bus.overflow_err !== 1'b0 || bus.wen !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: bin=%b gray=%b full=%b ovf=%b wen=%b want all 0",
                  bus.wptr_bin, bus.wptr_gray, bus.full, bus.overflow_err, bus.wen);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0);
      vectors++;
      if (bus.wptr_bin !== 3'b100 || bus.wptr_gray !== 3'b110 || bus.full !== 1'b1) begin
         miscompares++;
         $display("FAIL fill: bin=%b gray=%b full=%b want 100 110 1",
                  bus.wptr_bin, bus.wptr_gray, bus.full);
      end
      cyc(0, 1, 0);
      vectors++;
      if (bus.wptr_bin !== 3'b100 || bus.overflow_err !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow: bin=%b ovf=%b want 100 1", bus.wptr_bin, bus.overflow_err);
      end
      cyc(0, 0, 0);
      vectors++;
      if (bus.overflow_err !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: got %b want 1", bus.overflow_err);
      end
   endtask

   task automatic test_drain();
      rd_ptr = 1;
      cyc(0, 0, rd_ptr);
      cyc(0, 0, rd_ptr);
      vectors++;
      if (bus.rptr_bin_sync !== 3'b001 || bus.full !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_edge2: sync=%b full=%b want 001 1", bus.rptr_bin_sync, bus.full);
      end
      cyc(0, 0, rd_ptr);
      vectors++;
      if (bus.full !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_edge3: full=%b want 0", bus.full);
      end
      cyc(0, 1, rd_ptr);
      vectors++;
      if (bus.wptr_bin !== 3'b101 || bus.full !== 1'b1) begin
         miscompares++;
         $display("FAIL refill: bin=%b full=%b want 101 1", bus.wptr_bin, bus.full);
      end
   endtask

   task automatic test_reset_mid();
      rd_ptr = 5;
      for (int i = 0; i < 3; i++) cyc(0, 0, rd_ptr);
      cyc(0, 1, rd_ptr);
      cyc(0, 1, rd_ptr);
      vectors++;
      if (bus.wptr_bin !== 3'b111 || bus.overflow_err !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_mid_reset: bin=%b ovf=%b want 111 1", bus.wptr_bin, bus.overflow_err);
      end
      cyc(1, 1, rd_ptr);
      vectors++;
      if (bus.wptr_bin !== 3'b000 || bus.wptr_gray !== 3'b000 || bus.full !== 1'b0 ||
          bus.overflow_err !== 1'b0 || bus.rptr_bin_sync !== 3'b000 || bus.almost_full !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: bin=%b gray=%b full=%b ovf=%b sync=%b af=%b want all 0",
                  bus.wptr_bin, bus.wptr_gray, bus.full, bus.overflow_err,
                  bus.rptr_bin_sync, bus.almost_full);
      end
      rd_ptr = 0;
      cyc(1, 0, rd_ptr);
   endtask

   task automatic test_wrap();
      logic [ADDR:0] prev;
      prev = bus.wptr_gray;
      for (int i = 0; i < 9; i++) begin
         rd_ptr = m_w;
         cyc(0, 1, rd_ptr);
         vectors++;
         if ($countones(bus.wptr_gray ^ prev) != 1 || bus.full !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_step%0d: gray %b->%b full=%b want one bit change, full 0",
                     i, prev, bus.wptr_gray, bus.full);
         end
         if (i == 7) begin
            vectors++;
            if (bus.wptr_bin !== 3'b000 || bus.wptr_gray !== 3'b000) begin
               miscompares++;
               $display("FAIL wrap_zero: bin=%b gray=%b want 000 000", bus.wptr_bin, bus.wptr_gray);
            end
         end
         prev = bus.wptr_gray;
      end
      vectors++;
      if (bus.wptr_bin !== 3'b001 || bus.wptr_gray !== 3'b001) begin
         miscompares++;
         $display("FAIL wrap_end: bin=%b gray=%b want 001 001", bus.wptr_bin, bus.wptr_gray);
      end
   endtask

   task automatic test_random();
      bit r;
      bit w;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 63) == 0);
         w = ($urandom_range(0, 3) != 0);
         if (r) begin
            rd_ptr = 0;
         end else if (((m_w - rd_ptr + PMOD) % PMOD) > 0 && $urandom_range(0, 2) == 0) begin
            rd_ptr = (rd_ptr + 1) % PMOD;
         end
         cyc(r, w, rd_ptr);
      end
   endtask

   task automatic test_almost_full();
      bit exp_af;
      rd_ptr = 0;
      cyc(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0);
`ifdef FIFO_WR_ALMOST_FULL_EN
         exp_af = (i == 2);
`else
         exp_af = 1'b0;
`endif
         vectors++;
         if (bus.almost_full !== exp_af || bus.full !== 1'b0) begin
            miscompares++;
            $display("FAIL almost_full_w%0d: af=%b full=%b want af=%b full=0",
                     i, bus.almost_full, bus.full, exp_af);
         end
      end
      cyc(0, 1, 0);
   endtask

   initial begin
      rst                 = 1'b1;
      bus.winc            = 1'b0;
      bus.rptr_gray_async = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_drain();
      test_reset_mid();
      test_wrap();
      test_random();
      test_almost_full();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
